dmem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-port byte-addressed data memory.
- Requester 0 is the CPU load/store unit; requester 1 is the debug/program-load port, which writes test data and reads back results.
- Arbitrates and latches one request, then drives the memory for exactly one cycle.
- Registers the read data and returns a response under a valid/ready handshake.

---
 rtl/dmem_arb_pkg.sv | 39 +++
 rtl/dmem_arbiter_rr_arb2.sv | 19 +
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam int SRC_UNSIGNED_BIT = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  src;
    } mem_req_t;

    // The memory only stores one byte for size 11, so it is promoted to a word.
    function automatic logic [2:0] norm_src(input logic [2:0] s);
        logic [1:0] sz;
        sz = (s[1:0] == 2'b11) ? SZ_W : s[1:0];
        return {s[SRC_UNSIGNED_BIT], sz};
    endfunction

    function automatic logic misaligned(input logic [2:0] s, input logic [1:0] a);
        logic m;
        case (s[1:0])
            SZ_H:    m = a[0];
            SZ_W:    m = |a;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on ties, or requester 0 first when fixed_prio is set.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (fixed_prio || last_grant) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a single-port data memory: latch, issue one cycle, respond.
// Optional misaligned-access trap enabled by defining DMEM_ARB_MISALIGN_TRAP_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int A_WIDTH    = 20,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req_valid,
    input  logic        r1_req_valid,
    output logic        r0_req_ready,
    output logic        r1_req_ready,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r0_wdata,
    input  logic [31:0] r1_wdata,
    input  logic        r0_we,
    input  logic        r1_we,
    input  logic [2:0]  r0_src,
    input  logic [2:0]  r1_src,
    output logic        r0_rsp_valid,
    output logic        r1_rsp_valid,
    input  logic        r0_rsp_ready,
    input  logic        r1_rsp_ready,
    output logic [31:0] r0_rdata,
    output logic [31:0] r1_rdata,
    output logic        r0_err,
    output logic        r1_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [2:0]  mem_src,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] ADDR_MASK =
        (A_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << A_WIDTH) - 32'd1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    mem_req_t    req_q, req_d;
    logic        gid_q, gid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;

    logic [1:0]  grant;
    logic [1:0]  req_ready;
    mem_req_t    sel;
    logic        rsp_ready_g;
    logic        issue;

    rr_arb2 u_arb (
        .req        ({r1_req_valid, r0_req_valid}),
        .last_grant (last_grant_q),
        .fixed_prio (FIXED_PRIO != 0),
        .grant      (grant)
    );

    always_comb begin
        sel.addr  = grant[1] ? r1_addr  : r0_addr;
        sel.wdata = grant[1] ? r1_wdata : r0_wdata;
        sel.we    = grant[1] ? r1_we    : r0_we;
        sel.src   = norm_src(grant[1] ? r1_src : r0_src);
    end

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    assign req_ready   = (state_q == IDLE && rst_n) ? grant : 2'b00;
    assign rsp_ready_g = gid_q ? r1_rsp_ready : r0_rsp_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        gid_d        = gid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    req_d   = sel;
                    gid_d   = grant[1];
                    state_d = ISSUE;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
                    if (misaligned(sel.src, sel.addr[1:0])) begin
                        rdata_d     = 32'h0;
                        err_d       = 1'b1;
                        rsp_valid_d = grant[1] ? 2'b10 : 2'b01;
                        state_d     = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                rdata_d     = req_q.we ? 32'h0 : mem_rd;
                err_d       = 1'b0;
                rsp_valid_d = gid_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_g) begin
                    rsp_valid_d  = 2'b00;
                    rdata_d      = 32'h0;
                    err_d        = 1'b0;
                    last_grant_d = gid_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            req_q        <= '0;
            gid_q        <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            gid_q        <= gid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    // Memory drive comes straight from the state flop, so an async reset kills mem_we at once.
    assign issue   = (state_q == ISSUE);
    assign mem_a   = issue ? (req_q.addr & ADDR_MASK) : 32'h0;
    assign mem_wd  = issue ? req_q.wdata : 32'h0;
    assign mem_we  = issue & req_q.we;
    assign mem_src = issue ? req_q.src : 3'b000;

    assign r0_req_ready = req_ready[0];
    assign r1_req_ready = req_ready[1];
    assign r0_rsp_valid = rsp_valid_q[0];
    assign r1_rsp_valid = rsp_valid_q[1];
    assign r0_rdata     = rsp_valid_q[0] ? rdata_q : 32'h0;
    assign r1_rdata     = rsp_valid_q[1] ? rdata_q : 32'h0;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    assign r0_err = rsp_valid_q[0] & err_q;
    assign r1_err = rsp_valid_q[1] & err_q;
`else
    assign r0_err = 1'b0;
    assign r1_err = 1'b0;
`endif

endmodule
